stopwatch_led_sequencer: RTL and testbench
==========================================

// Module: stopwatch_led_sequencer
// PURPOSE
//  Run/pause/clear controller that sequences the LED animation datapath.
//  It divides clk into a seconds tick and keeps a BCD seconds count 00..59.
//  Its n1/n0/anim_reset outputs drive the LED animator's digit and reset inputs directly.
//  A lap function freezes the displayed digits while counting continues underneath.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per count tick (>=2); benches use 4
//  MAX_TENS  5            tens digit at which the count wraps (with units 9)
// PORTS
//  clk          in   1  system clock, all logic rising-edge
//  reset        in   1  asynchronous, active-high; forces all state to reset values
//  start_stop   in   1  one-cycle pulse (pre-debounced): start or pause/resume
//  clear        in   1  one-cycle pulse: return to IDLE, count 00
//  lap          in   1  one-cycle pulse: toggle display freeze (RUN only)
//  n1           out  4  displayed tens digit, BCD 0..MAX_TENS
//  n0           out  4  displayed units digit, BCD 0..9
//  anim_reset   out  1  drives LED animator reset; 1 in IDLE, else 0
//  running      out  1  1 while state==RUN
//  wrap         out  1  one-cycle pulse on internal count MAX_TENS9 -> 00
//  lap_held     out  1  1 while display is frozen
// BEHAVIOUR
//  Reset values: state IDLE, prescaler 0, internal count 00, n1=n0=0,
//   anim_reset=1, running=0, wrap=0, lap_held=0. All outputs registered.
//  FSM states IDLE, RUN, PAUSE; per-cycle input priority clear > start_stop > lap.
//   clear (any state): -> IDLE; prescaler, count, lap_held cleared next edge.
//   IDLE + start_stop -> RUN; prescaler starts from 0.
//   RUN  + start_stop -> PAUSE; prescaler and count hold their values.
//   PAUSE + start_stop -> RUN; resumes from the held prescaler value (no tick loss).
//   lap in RUN toggles lap_held; lap in IDLE/PAUSE ignored.
//   lap_held is kept on RUN->PAUSE->RUN and cleared only by clear/reset.
//  Prescaler: counts only in RUN, 0..TICK_DIV-1. tick=1 in the cycle it equals
//   TICK_DIV-1; it returns to 0 at the same edge.
//  Count: on tick, units+1; at units 9 -> units 0, tens+1; at MAX_TENS/9 -> 00
//   and wrap=1 for exactly the next cycle. Digits never leave BCD range.
//  Display: n1/n0 = internal count, 1 cycle after the count register updates
//   (2 cycles after the tick cycle), unless lap_held=1. While held, n1/n0 hold
//   the value frozen at the lap pulse. On release they resync to the live count 1 cycle later.
//  anim_reset updates with the state register: 1 the cycle after entering IDLE,
//   0 the cycle after leaving it. running follows state the same way.
//  start_stop and clear asserted together: clear wins, state IDLE.
//  start_stop and tick in the same cycle (RUN): that tick still counts, then PAUSE.
//  Async reset mid-count: all outputs at reset values immediately; no pending wrap.
// TESTING (TICK_DIV=4, MAX_TENS=5)
//  reset, start_stop at cycle 0 -> anim_reset 1->0, running=1; n0=1 after 4 ticks of clk +2.
//  run 60 ticks -> n1/n0 sequence 00..59 then 00, wrap high exactly one cycle at 59->00.
//  pause at prescaler=2, wait 50 cycles, resume -> next n0 increment exactly 2 clk later.
//  lap at count 12, run 5 ticks -> n1/n0 stay 1/2, lap_held=1; lap again -> shows 17.
//  clear+start_stop same cycle while RUN at 34 -> IDLE, n1=n0=0, anim_reset=1, lap_held=0.
//  assert reset mid-run at count 47 -> all outputs reset asynchronously, no wrap pulse.

Source files
------------

// File: rtl/stopwatch_led_sequencer.sv
// Run/pause/clear seconds stopwatch (BCD 00..MAX_TENS9) that drives the LED animator's
// digit and reset inputs, with a lap function that freezes the displayed digits.
module stopwatch_led_sequencer #(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MAX_TENS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] n1,
  output logic [3:0] n0,
  output logic       anim_reset,
  output logic       running,
  output logic       wrap,
  output logic       lap_held
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      tens_q, tens_d, units_q, units_d;
  logic [3:0]      n1_q, n1_d, n0_q, n0_d;
  logic            lap_held_q, lap_held_d;
  logic            wrap_q, wrap_d;
  logic            anim_q, anim_d;
  logic            run_q, run_d;
  logic            tick;

  assign tick = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    tens_d     = tens_q;
    units_d    = units_q;
    n1_d       = n1_q;
    n0_d       = n0_q;
    lap_held_d = lap_held_q;
    wrap_d     = 1'b0;

    if (tick) begin
      if (units_q == 4'd9) begin
        units_d = '0;
        if (tens_q == 4'(MAX_TENS)) begin
          tens_d = '0;
          wrap_d = 1'b1;
        end else begin
          tens_d = tens_q + 4'd1;
        end
      end else begin
        units_d = units_q + 4'd1;
      end
    end

    if (state_q == RUN) presc_d = tick ? '0 : presc_q + PW'(1);

    // Display trails the count register by one edge; frozen while lap is held.
    if (!lap_held_q) begin
      n1_d = tens_q;
      n0_d = units_q;
    end

    if (clear) begin
      state_d    = IDLE;
      presc_d    = '0;
      tens_d     = '0;
      units_d    = '0;
      n1_d       = '0;
      n0_d       = '0;
      lap_held_d = 1'b0;
      wrap_d     = 1'b0;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE: begin
          state_d = RUN;
          presc_d = '0;
        end
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (lap && state_q == RUN) begin
      lap_held_d = ~lap_held_q;
    end

    anim_d = (state_d == IDLE);
    run_d  = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      n1_q       <= '0;
      n0_q       <= '0;
      lap_held_q <= 1'b0;
      wrap_q     <= 1'b0;
      anim_q     <= 1'b1;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      n1_q       <= n1_d;
      n0_q       <= n0_d;
      lap_held_q <= lap_held_d;
      wrap_q     <= wrap_d;
      anim_q     <= anim_d;
      run_q      <= run_d;
    end
  end

  assign n1         = n1_q;
  assign n0         = n0_q;
  assign anim_reset = anim_q;
  assign running    = run_q;
  assign wrap       = wrap_q;
  assign lap_held   = lap_held_q;

endmodule

// File: tb/tb_stopwatch_led_sequencer.sv
// Bench for stopwatch_led_sequencer: directed scenarios plus random pulses, all checked
// every cycle against a seconds-as-integer reference model.
module tb_stopwatch_led_sequencer;

  localparam int DIV  = 4;
  localparam int MT   = 5;
  localparam int MODN = (MT + 1) * 10;

  logic       clk = 1'b0;
  logic       reset, start_stop, clear, lap;
  logic [3:0] n1, n0;
  logic       anim_reset, running, wrap, lap_held;

  stopwatch_led_sequencer #(.TICK_DIV(DIV), .MAX_TENS(MT)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .n1(n1), .n0(n0), .anim_reset(anim_reset), .running(running),
    .wrap(wrap), .lap_held(lap_held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode 0=idle 1=run 2=pause, seconds as a plain integer.
  int m_mode, m_pre, m_sec, m_disp, m_held, m_wrap;
  int obs_n0, obs_n1, obs_run, obs_wrap, obs_held;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pre = 0; m_sec = 0; m_disp = 0; m_held = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int tick, osec;
    tick = (m_mode == 1 && m_pre == DIV - 1) ? 1 : 0;
    if (clear) begin
      model_reset();
    end else begin
      osec   = m_sec;
      m_wrap = (tick == 1 && m_sec == MODN - 1) ? 1 : 0;
      if (tick == 1) m_sec = (m_sec + 1) % MODN;
      if (m_held == 0) m_disp = osec;
      if (m_mode == 1) m_pre = (tick == 1) ? 0 : m_pre + 1;
      if (start_stop) begin
        if (m_mode == 0) begin m_mode = 1; m_pre = 0; end
        else if (m_mode == 1) m_mode = 2;
        else m_mode = 1;
      end else if (lap && m_mode == 1) begin
        m_held = 1 - m_held;
      end
    end
  endtask

  task automatic check_outputs();
    chk("n1", int'(n1), m_disp / 10);
    chk("n0", int'(n0), m_disp % 10);
    chk("anim_reset", int'(anim_reset), (m_mode == 0) ? 1 : 0);
    chk("running", int'(running), (m_mode == 1) ? 1 : 0);
    chk("wrap", int'(wrap), m_wrap);
    chk("lap_held", int'(lap_held), m_held);
  endtask

  // One clock cycle: check and record outputs, drive inputs, advance the model at the edge.
  task automatic cyc(input logic ss, input logic cl, input logic lp);
    @(negedge clk);
    obs_n0 = int'(n0); obs_n1 = int'(n1); obs_run = int'(running);
    obs_wrap = int'(wrap); obs_held = int'(lap_held);
    check_outputs();
    start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    model_step();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_n1"}, int'(n1), 0);
    chk({tag, "_n0"}, int'(n0), 0);
    chk({tag, "_anim"}, int'(anim_reset), 1);
    chk({tag, "_run"}, int'(running), 0);
    chk({tag, "_wrap"}, int'(wrap), 0);
    chk({tag, "_held"}, int'(lap_held), 0);
  endtask

  task automatic wait_sec(input int sec, input string tag);
    int budget = 2000;
    while (!(m_sec == sec && m_pre == 0 && m_mode == 1) && budget > 0) begin
      cyc(1'b0, 1'b0, 1'b0);
      budget--;
    end
    if (budget == 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int lat, t_run, t_chg, wraps, prev_n0, budget;
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_values("por");
    @(negedge clk) reset = 1'b0;

    // Start: first n0 increment appears DIV+2 cycles after the start pulse.
    cyc(1'b1, 1'b0, 1'b0);
    lat = 0; budget = 50;
    do begin cyc(1'b0, 1'b0, 1'b0); lat++; budget--; end while (obs_n0 != 1 && budget > 0);
    chk("start_latency", lat, DIV + 2);

    // Pause with prescaler at 2, hold 50 cycles, resume.
    budget = 50;
    while (!(m_mode == 1 && m_pre == 2) && budget > 0) begin cyc(1'b0, 1'b0, 1'b0); budget--; end
    if (budget == 0) chk("pause_timeout", 0, 1);
    cyc(1'b1, 1'b0, 1'b0);
    prev_n0 = int'(n0);
    repeat (50) cyc(1'b0, 1'b0, 1'b0);
    chk("pause_hold_n0", obs_n0, prev_n0);
    cyc(1'b1, 1'b0, 1'b0);
    t_run = -1; t_chg = -1;
    for (int k = 1; k <= 20 && t_chg < 0; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (t_run < 0 && obs_run == 1) t_run = k;
      if (obs_n0 != prev_n0) t_chg = k;
    end
    chk("resume_to_incr", t_chg - t_run, 2);

    // Lap at 12: frozen through 5 ticks, release shows 17.
    wait_sec(12, "lap12");
    cyc(1'b0, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("lap_frozen", obs_n1 * 10 + obs_n0, 12);
    chk("lap_held_on", obs_held, 1);
    cyc(1'b0, 1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    chk("lap_release", obs_n1 * 10 + obs_n0, 17);

    // Clear together with start_stop at 34 while lap is held.
    wait_sec(30, "lap30");
    cyc(1'b0, 1'b0, 1'b1);
    wait_sec(34, "clr34");
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clr_held_off", obs_held, 0);
    #1 check_reset_values("clear");

    // Full minute: exactly one wrap pulse.
    cyc(1'b1, 1'b0, 1'b0);
    wraps = 0;
    repeat (MODN * DIV + 2) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (obs_wrap == 1) wraps++;
    end
    chk("wrap_count", wraps, 1);

    // Asynchronous reset mid-run at 47.
    wait_sec(47, "rst47");
    @(negedge clk);
    check_outputs();
    #2 reset = 1'b1;
    #1 check_reset_values("async");
    model_reset();
    @(posedge clk);
    #1 chk("async_wrap", int'(wrap), 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);

    // Random pulse traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 99) == 0), ($urandom_range(0, 11) == 0));
    end
    cyc(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
